uart_frame_gen: RTL and testbench

Parametrised UART frame generator. Accepts data words over a valid/ready handshake into an internal FIFO and serialises each word onto a single TX line as start, data (LSB first), optional parity and one or two stop bits, followed by a programmable idle gap. The bit period is set at run time by a prescale value. It sits in front of the system's UART RX path and replaces hand-timed serial stimulus. The same instance can also act as a loopback/BIST source.

---
 rtl/uart_frame_gen.sv | 198 +++++++++++++++++++
 tb/tb_uart_frame_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_gen.sv
// rtl/uart_frame_gen.sv - UART frame generator with word FIFO; optional error injection under UART_FRAME_ERR_INJ_EN
module uart_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [PRESC_WIDTH-1:0]      PRESCALE,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic                        STOP2,
  input  logic [3:0]                  GAP_BITS,
`ifdef UART_FRAME_ERR_INJ_EN
  input  logic                        IN_PERR,
  input  logic                        IN_FERR,
`endif
  input  logic [DATA_WIDTH-1:0]       IN_DATA,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic                        TX_OUT,
  output logic                        BUSY,
  output logic                        FRAME_DONE,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_FRAME_ERR_INJ_EN
  localparam int WW = DATA_WIDTH + 2;
`else
  localparam int WW = DATA_WIDTH;
`endif
  localparam logic [AW:0]            DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [IW-1:0]          LAST_BIT = IW'(DATA_WIDTH-1);
  localparam logic [PRESC_WIDTH-1:0] P_ONE    = PRESC_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  logic [WW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   push, pop;
  logic [WW-1:0]          wdata, rdata;
  logic                   perr_w, ferr_w;

  state_t                 state;
  logic [PRESC_WIDTH-1:0] cnt, presc_r, presc_eff;
  logic [IW-1:0]          bit_idx;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic                   par_en_r, par_bit_r, stop2_r, stop_idx, stop1_lvl_r;
  logic [3:0]             gap_r, gap_idx;
  logic                   bit_end, last_stop, will_end;

`ifdef UART_FRAME_ERR_INJ_EN
  assign wdata  = {IN_FERR, IN_PERR, IN_DATA};
  assign perr_w = rdata[DATA_WIDTH];
  assign ferr_w = rdata[DATA_WIDTH+1];
`else
  assign wdata  = IN_DATA;
  assign perr_w = 1'b0;
  assign ferr_w = 1'b0;
`endif

  assign IN_READY   = !RST && (count < DEPTH_C);
  assign FIFO_COUNT = count;
  assign push       = IN_VALID && IN_READY;
  assign pop        = (state == IDLE) && (count != '0);
  assign rdata      = mem[rd_ptr];
  assign presc_eff  = (PRESCALE == '0) ? P_ONE : PRESCALE;
  assign bit_end    = (cnt == presc_r - P_ONE);
  // next cycle is the last cycle of the current bit
  assign will_end   = (cnt + P_ONE == presc_r - P_ONE);
  assign last_stop  = !stop2_r || stop_idx;

  // word FIFO: a full FIFO blocks the push even when a pop happens that cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // frame FSM with registered line, busy and done outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      TX_OUT      <= 1'b1;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
      cnt         <= '0;
      presc_r     <= P_ONE;
      bit_idx     <= '0;
      shift_r     <= '0;
      par_en_r    <= 1'b0;
      par_bit_r   <= 1'b0;
      stop2_r     <= 1'b0;
      stop_idx    <= 1'b0;
      stop1_lvl_r <= 1'b1;
      gap_r       <= '0;
      gap_idx     <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          if (pop) begin
            shift_r     <= rdata[DATA_WIDTH-1:0];
            presc_r     <= presc_eff;
            par_en_r    <= PAR_EN;
            par_bit_r   <= (^rdata[DATA_WIDTH-1:0]) ^ PAR_TYP ^ perr_w;
            stop2_r     <= STOP2;
            gap_r       <= GAP_BITS;
            stop1_lvl_r <= ~ferr_w;
            cnt         <= '0;
            TX_OUT      <= 1'b0;
            BUSY        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            TX_OUT  <= shift_r[0];
            shift_r <= shift_r >> 1;
            state   <= DATA;
          end else cnt <= cnt + P_ONE;
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              if (par_en_r) begin
                TX_OUT <= par_bit_r;
                state  <= PARITY;
              end else begin
                TX_OUT     <= stop1_lvl_r;
                stop_idx   <= 1'b0;
                FRAME_DONE <= (presc_r == P_ONE) && !stop2_r;
                state      <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
              TX_OUT  <= shift_r[0];
              shift_r <= shift_r >> 1;
            end
          end else cnt <= cnt + P_ONE;
        end
        PARITY: begin
          if (bit_end) begin
            cnt        <= '0;
            TX_OUT     <= stop1_lvl_r;
            stop_idx   <= 1'b0;
            FRAME_DONE <= (presc_r == P_ONE) && !stop2_r;
            state      <= STOP;
          end else cnt <= cnt + P_ONE;
        end
        STOP: begin
          if (bit_end) begin
            cnt    <= '0;
            TX_OUT <= 1'b1;
            if (!last_stop) begin
              stop_idx   <= 1'b1;
              FRAME_DONE <= (presc_r == P_ONE);
            end else if (gap_r != '0) begin
              gap_idx <= '0;
              state   <= GAP;
            end else begin
              BUSY  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt        <= cnt + P_ONE;
            FRAME_DONE <= last_stop && will_end;
          end
        end
        GAP: begin
          if (bit_end) begin
            cnt <= '0;
            if (gap_idx == gap_r - 4'd1) begin
              BUSY  <= 1'b0;
              state <= IDLE;
            end else gap_idx <= gap_idx + 4'd1;
          end else cnt <= cnt + P_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_gen.sv
// tb/tb_uart_frame_gen.sv - directed self-checking bench for uart_frame_gen
`timescale 1ns/1ps
module tb_uart_frame_gen;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
  logic [3:0] GAP_BITS = 4'd0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_VALID = 1'b0;
  logic       IN_READY, TX_OUT, BUSY, FRAME_DONE;
  logic [2:0] FIFO_COUNT;
`ifdef UART_FRAME_ERR_INJ_EN
  logic       IN_PERR = 1'b0, IN_FERR = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic tx_log[$];
  logic fd_log[$];
  logic busy_log[$];
  logic log_en = 1'b0;

  uart_frame_gen #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .GAP_BITS(GAP_BITS),
`ifdef UART_FRAME_ERR_INJ_EN
    .IN_PERR(IN_PERR), .IN_FERR(IN_FERR),
`endif
    .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .TX_OUT(TX_OUT),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  // record outputs 1ns after every rising edge while logging is on
  always begin
    @(posedge CLK);
    #1;
    if (log_en) begin
      tx_log.push_back(TX_OUT);
      fd_log.push_back(FRAME_DONE);
      busy_log.push_back(BUSY);
    end
  end

  // push one word at edge N; log entry 0 follows edge N, entry k follows edge N+k
  task automatic run_capture(input logic [7:0] d, input int ncyc);
    @(negedge CLK);
    tx_log.delete();
    fd_log.delete();
    busy_log.delete();
    log_en   = 1'b1;
    IN_DATA  = d;
    IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
`ifdef UART_FRAME_ERR_INJ_EN
    IN_PERR = 1'b0;
    IN_FERR = 1'b0;
`endif
    repeat (ncyc) @(posedge CLK);
    @(negedge CLK);
    log_en = 1'b0;
  endtask

  task automatic test_reset();
    IN_VALID = 1'b1;
    IN_DATA  = 8'h11;
    repeat (2) @(negedge CLK);
    n_cmp++; if (TX_OUT !== 1'b1) begin n_err++; $display("FAIL rst_tx got %b want 1", TX_OUT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", BUSY); end
    n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", FRAME_DONE); end
    n_cmp++; if (FIFO_COUNT !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", FIFO_COUNT); end
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", IN_READY); end
    IN_VALID = 1'b0;
    RST      = 1'b0;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL ready_after_rst got %b want 1", IN_READY); end
  endtask

  task automatic test_even_parity();
    logic e [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; GAP_BITS = 4'd0;
    run_capture(8'hAA, 95);
    n_cmp++; if (tx_log[0] !== 1'b1) begin n_err++; $display("FAIL even_latency got %b want 1", tx_log[0]); end
    for (int c = 1; c <= 88; c++) begin
      n_cmp++; if (tx_log[c] !== e[(c-1)/8]) begin n_err++; $display("FAIL even_tx c=%0d got %b want %b", c, tx_log[c], e[(c-1)/8]); end
      n_cmp++; if (fd_log[c] !== (c == 88)) begin n_err++; $display("FAIL even_done c=%0d got %b want %b", c, fd_log[c], (c == 88)); end
      n_cmp++; if (busy_log[c] !== 1'b1) begin n_err++; $display("FAIL even_busy c=%0d got %b want 1", c, busy_log[c]); end
    end
    n_cmp++; if (tx_log[89] !== 1'b1) begin n_err++; $display("FAIL even_after_tx got %b want 1", tx_log[89]); end
    n_cmp++; if (busy_log[89] !== 1'b0) begin n_err++; $display("FAIL even_after_busy got %b want 0", busy_log[89]); end
  endtask

  task automatic test_odd_stop2();
    logic e [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1; GAP_BITS = 4'd0;
    run_capture(8'h0F, 103);
    for (int c = 1; c <= 96; c++) begin
      n_cmp++; if (tx_log[c] !== e[(c-1)/8]) begin n_err++; $display("FAIL odd_tx c=%0d got %b want %b", c, tx_log[c], e[(c-1)/8]); end
      n_cmp++; if (fd_log[c] !== (c == 96)) begin n_err++; $display("FAIL odd_done c=%0d got %b want %b", c, fd_log[c], (c == 96)); end
    end
    n_cmp++; if (busy_log[97] !== 1'b0) begin n_err++; $display("FAIL odd_after_busy got %b want 0", busy_log[97]); end
  endtask

  task automatic test_prescale_zero();
    logic e [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    PRESCALE = 6'd0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; GAP_BITS = 4'd0;
    run_capture(8'h5A, 13);
    for (int c = 1; c <= 10; c++) begin
      n_cmp++; if (tx_log[c] !== e[c-1]) begin n_err++; $display("FAIL p0_tx c=%0d got %b want %b", c, tx_log[c], e[c-1]); end
      n_cmp++; if (fd_log[c] !== (c == 10)) begin n_err++; $display("FAIL p0_done c=%0d got %b want %b", c, fd_log[c], (c == 10)); end
    end
    n_cmp++; if (busy_log[11] !== 1'b0) begin n_err++; $display("FAIL p0_after_busy got %b want 0", busy_log[11]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [5] = '{8'h0A, 8'h0F, 8'hBB, 8'h0A, 8'h55};
    logic [2:0] cnts  [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] wv;
    logic       want;
    int         s, highs, fds;
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; GAP_BITS = 4'd2;
    @(negedge CLK);
    tx_log.delete(); fd_log.delete(); busy_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      IN_DATA  = words[i];
      IN_VALID = 1'b1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_ready i=%0d got %b want 1", i, IN_READY); end
      @(posedge CLK);
      #1;
      n_cmp++; if (FIFO_COUNT !== cnts[i]) begin n_err++; $display("FAIL b2b_count i=%0d got %0d want %0d", i, FIFO_COUNT, cnts[i]); end
    end
    IN_DATA = 8'hEE;
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got %b want 0", IN_READY); end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    n_cmp++; if (FIFO_COUNT !== 3'd4) begin n_err++; $display("FAIL b2b_full_count got %0d want 4", FIFO_COUNT); end
    repeat (490) @(posedge CLK);
    @(negedge CLK);
    log_en = 1'b0;
    fds = 0;
    foreach (fd_log[i]) if (fd_log[i] === 1'b1) fds++;
    n_cmp++; if (fds != 5) begin n_err++; $display("FAIL b2b_done_count got %0d want 5", fds); end
    for (int k = 0; k < 5; k++) begin
      s  = 1 + 97 * k;
      wv = words[k];
      for (int c = 0; c < 80; c++) begin
        if (c / 8 == 0) want = 1'b0;
        else if (c / 8 == 9) want = 1'b1;
        else want = wv[c/8 - 1];
        n_cmp++; if (tx_log[s+c] !== want) begin n_err++; $display("FAIL b2b_tx k=%0d c=%0d got %b want %b", k, c, tx_log[s+c], want); end
      end
      n_cmp++; if (fd_log[s+79] !== 1'b1) begin n_err++; $display("FAIL b2b_done k=%0d got %b want 1", k, fd_log[s+79]); end
      if (k < 4) begin
        highs = 0;
        for (int c = 80; c < 97; c++) if (tx_log[s+c] === 1'b1) highs++;
        n_cmp++; if (highs != 17) begin n_err++; $display("FAIL b2b_gap k=%0d got %0d want 17", k, highs); end
        n_cmp++; if (tx_log[s+97] !== 1'b0) begin n_err++; $display("FAIL b2b_next_start k=%0d got %b want 0", k, tx_log[s+97]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] words [3] = '{8'h33, 8'h44, 8'h55};
    int highs, fds;
    PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; GAP_BITS = 4'd0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      IN_DATA  = words[i];
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
    end
    IN_VALID = 1'b0;
    repeat (92) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (TX_OUT !== 1'b0) begin n_err++; $display("FAIL mid_pre_tx got %b want 0", TX_OUT); end
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy got %b want 1", BUSY); end
    n_cmp++; if (FIFO_COUNT !== 3'd1) begin n_err++; $display("FAIL mid_pre_count got %0d want 1", FIFO_COUNT); end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    n_cmp++; if (TX_OUT !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx got %b want 1", TX_OUT); end
    n_cmp++; if (FIFO_COUNT !== 3'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", FIFO_COUNT); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", BUSY); end
    n_cmp++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL mid_rst_done got %b want 0", FRAME_DONE); end
    @(negedge CLK);
    RST   = 1'b0;
    highs = 0;
    fds   = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      if (TX_OUT === 1'b1) highs++;
      if (FRAME_DONE === 1'b1) fds++;
    end
    n_cmp++; if (highs != 120) begin n_err++; $display("FAIL mid_flush_tx got %0d want 120", highs); end
    n_cmp++; if (fds != 0) begin n_err++; $display("FAIL mid_flush_done got %0d want 0", fds); end
  endtask

`ifdef UART_FRAME_ERR_INJ_EN
  task automatic test_err_inj();
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0; GAP_BITS = 4'd0;
    IN_PERR = 1'b1;
    run_capture(8'hAA, 95);
    for (int c = 73; c <= 80; c++) begin
      n_cmp++; if (tx_log[c] !== 1'b1) begin n_err++; $display("FAIL perr_tx c=%0d got %b want 1", c, tx_log[c]); end
    end
    PAR_EN  = 1'b0;
    IN_FERR = 1'b1;
    run_capture(8'hAA, 90);
    for (int c = 73; c <= 80; c++) begin
      n_cmp++; if (tx_log[c] !== 1'b0) begin n_err++; $display("FAIL ferr_tx c=%0d got %b want 0", c, tx_log[c]); end
    end
    n_cmp++; if (tx_log[81] !== 1'b1) begin n_err++; $display("FAIL ferr_after got %b want 1", tx_log[81]); end
  endtask
`endif

  initial begin
    test_reset();
    test_even_parity();
    test_odd_stop2();
    test_prescale_zero();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_FRAME_ERR_INJ_EN
    test_err_inj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
